dct_block_scheduler: RTL
========================

DCT_BLOCK_SCHEDULER -- requirements
Module: dct_block_scheduler

Interface
REQ-001 SHALL have parameter BLOCKS_PER_FRAME, default 1200, meaning the number of 8x8 blocks per frame (320x240).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4095, meaning the maximum number of cycles one 2-D DCT may run.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port nreset, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: the producer has finished filling input buffer in_wr_sel.
REQ-006 SHALL have port in_ready, output, 1 bit: at least one input buffer is free.
REQ-007 SHALL have port in_wr_sel, output, 1 bit: the input ping-pong buffer the producer fills next.
REQ-008 SHALL have port dct_rd_sel, output, 1 bit: the input buffer the DCT engine reads; it drives the upper fetch-address bit.
REQ-009 SHALL have port dct_wr_sel, output, 1 bit: the output ping-pong buffer the DCT engine writes; it drives the upper result-address bit.
REQ-010 SHALL have port dct_nreset, output, 1 bit: the active-low reset to the 2-D DCT engine.
REQ-011 SHALL have port dct_finished, input, 1 bit: the finished flag from the 2-D DCT engine; it stays high until the engine is reset.
REQ-012 SHALL have port out_valid, output, 1 bit: at least one output buffer holds coefficients.
REQ-013 SHALL have port out_rd_sel, output, 1 bit: the output buffer the consumer reads.
REQ-014 SHALL have port out_release, input, 1 bit: a one-cycle pulse meaning the consumer has finished with buffer out_rd_sel.
REQ-015 SHALL have port frame_done, output, 1 bit: a one-cycle pulse when block BLOCKS_PER_FRAME-1 is committed.
REQ-016 SHALL have port err_timeout, output, 1 bit: sticky flag set when a DCT run exceeds TIMEOUT_CYCLES.

Function
REQ-017 SHALL track each ping-pong side (input and output) with a 2-bit count (0..2), a 1-bit write pointer and a 1-bit read pointer.
REQ-018 SHALL count a push on input when in_valid && in_ready; in_valid while !in_ready SHALL be ignored with no state change.
REQ-019 SHALL drive in_ready = (in_count != 2) and out_valid = (out_count != 0), both combinationally from registers.
REQ-020 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-021 IDLE SHALL go to RUN when in_count != 0 and out_count != 2.
REQ-022 In RUN, dct_finished high SHALL go to DONE.
REQ-023 In RUN, a cycle counter reaching TIMEOUT_CYCLES SHALL set err_timeout, pop the input buffer without committing output, and go to IDLE.
REQ-024 DONE SHALL pop the input buffer, commit (push) the output buffer, and go to IDLE unconditionally.
REQ-025 SHALL drive dct_nreset = (state == RUN), so the engine is held in reset for at least 2 cycles between blocks.
REQ-026 SHALL latch dct_rd_sel and dct_wr_sel on IDLE->RUN and hold them stable through RUN and DONE.
REQ-027 SHALL treat a simultaneous push and pop on the same side as leaving the count unchanged while both pointers advance.
REQ-028 SHALL make the pop happen before the push check, so a full input with a same-cycle pop still rejects in_valid (in_ready is registered-based).
REQ-029 SHALL ignore out_release when out_count == 0.
REQ-030 SHALL keep a block counter 0..BLOCKS_PER_FRAME-1 that increments on each DONE and wraps to 0, with frame_done asserted in the same cycle as the wrapping DONE.
REQ-031 SHALL ensure a timed-out block does not increment the block counter.
REQ-032 SHALL give the run-cycle counter a width of clog2(TIMEOUT_CYCLES+1), clear it on entry to RUN, and saturate it.

Reset
REQ-033 On nreset low, SHALL asynchronously set: state IDLE; all counts, pointers, latched selects and counters 0; err_timeout 0; frame_done 0; dct_nreset 0.
REQ-034 Reset during RUN SHALL abandon the block; the DCT engine is held in reset via dct_nreset.
REQ-035 err_timeout SHALL clear only on nreset.

Structure
REQ-036 Package jfpjc_dct_pkg SHALL hold the FSM state encoding and the default BLOCKS_PER_FRAME and TIMEOUT_CYCLES constants.
REQ-037 SHALL instantiate sub-module pingpong_tracker (count, rd pointer, wr pointer, push, pop) twice, once for input and once for output.

Verification
REQ-038 After reset, pulse in_valid once with the consumer idle -> RUN entered within 2 cycles with dct_rd_sel=0 and dct_wr_sel=0; dct_finished after 300 cycles -> DONE, then out_valid=1 and out_rd_sel=0.
REQ-039 Push 3 blocks back-to-back with the DCT stalled -> in_ready=0 after the 2nd push; the 3rd push is ignored and in_count stays 2.
REQ-040 Never release output -> after 2 committed blocks the FSM stays in IDLE with in_count=2; a single out_release -> RUN restarts next cycle with dct_wr_sel=0.
REQ-041 Hold dct_finished low with TIMEOUT_CYCLES=15 -> err_timeout=1 on cycle 15 of RUN, in_count decrements, out_count and the block counter are unchanged.
REQ-042 Run BLOCKS_PER_FRAME=4 through 5 blocks -> frame_done pulses exactly once, on the 4th DONE, and the counter reads 1 after the 5th.
REQ-043 Assert nreset mid-RUN -> the same cycle gives dct_nreset=0 and in_ready=1; after release, state is IDLE with all counts 0.

Source files
------------

// File: rtl/jfpjc_dct_pkg.sv
// Shared definitions for the DCT block scheduler: FSM encoding and default frame/timeout sizing.
package jfpjc_dct_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sched_state_e;

    // 320x240 frame split into 8x8 blocks
    localparam int unsigned DEF_BLOCKS_PER_FRAME = 1200;
    localparam int unsigned DEF_TIMEOUT_CYCLES   = 4095;

endpackage

// File: rtl/pingpong_tracker.sv
// Occupancy and pointer bookkeeping for one two-entry ping-pong buffer pair.
module pingpong_tracker (
    input  logic       clock_i,
    input  logic       nreset_i,
    input  logic       push_i,
    input  logic       pop_i,
    output logic [1:0] count_o,
    output logic       rd_ptr_o,
    output logic       wr_ptr_o
);

    logic [1:0] count_q, count_d;
    logic       rd_q, rd_d;
    logic       wr_q, wr_d;

    always_comb begin
        count_d = count_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        if (push_i) wr_d = ~wr_q;
        if (pop_i)  rd_d = ~rd_q;
        if (push_i && !pop_i)      count_d = count_q + 2'd1;
        else if (pop_i && !push_i) count_d = count_q - 2'd1;
    end

    always_ff @(posedge clock_i or negedge nreset_i) begin
        if (!nreset_i) begin
            count_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

    assign count_o  = count_q;
    assign rd_ptr_o = rd_q;
    assign wr_ptr_o = wr_q;

endmodule

// File: rtl/dct_block_scheduler.sv
// Schedules 8x8 blocks through a 2-D DCT engine between input and output ping-pong buffers.
module dct_block_scheduler
    import jfpjc_dct_pkg::*;
#(
    parameter int unsigned BLOCKS_PER_FRAME = DEF_BLOCKS_PER_FRAME,
    parameter int unsigned TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES
) (
    input  logic clock,
    input  logic nreset,
    input  logic in_valid,
    output logic in_ready,
    output logic in_wr_sel,
    output logic dct_rd_sel,
    output logic dct_wr_sel,
    output logic dct_nreset,
    input  logic dct_finished,
    output logic out_valid,
    output logic out_rd_sel,
    input  logic out_release,
    output logic frame_done,
    output logic err_timeout
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned BLK_W = (BLOCKS_PER_FRAME > 1) ? $clog2(BLOCKS_PER_FRAME) : 1;

    sched_state_e     state_q, state_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d, run_inc;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic             rd_sel_q, rd_sel_d;
    logic             wr_sel_q, wr_sel_d;
    logic             err_q, err_d;

    logic       in_push, in_pop, out_push, out_pop;
    logic [1:0] in_count, out_count;
    logic       in_rd_ptr, in_wr_ptr, out_rd_ptr, out_wr_ptr;

    pingpong_tracker u_in_trk (
        .clock_i  (clock),
        .nreset_i (nreset),
        .push_i   (in_push),
        .pop_i    (in_pop),
        .count_o  (in_count),
        .rd_ptr_o (in_rd_ptr),
        .wr_ptr_o (in_wr_ptr)
    );

    pingpong_tracker u_out_trk (
        .clock_i  (clock),
        .nreset_i (nreset),
        .push_i   (out_push),
        .pop_i    (out_pop),
        .count_o  (out_count),
        .rd_ptr_o (out_rd_ptr),
        .wr_ptr_o (out_wr_ptr)
    );

    // Readiness comes from registered counts only, so a same-cycle pop cannot admit a push into a full side
    assign in_ready = (in_count != 2'd2);
    assign in_push  = in_valid && in_ready;
    assign out_valid = (out_count != 2'd0);
    assign out_pop   = out_release && out_valid;

    assign run_inc = (run_cnt_q == CNT_W'(TIMEOUT_CYCLES)) ? run_cnt_q : run_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        run_cnt_d  = run_cnt_q;
        blk_d      = blk_q;
        rd_sel_d   = rd_sel_q;
        wr_sel_d   = wr_sel_q;
        err_d      = err_q;
        in_pop     = 1'b0;
        out_push   = 1'b0;
        dct_nreset = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_count != 2'd0 && out_count != 2'd2) begin
                    state_d   = ST_RUN;
                    run_cnt_d = '0;
                    rd_sel_d  = in_rd_ptr;
                    wr_sel_d  = out_wr_ptr;
                end
            end
            ST_RUN: begin
                dct_nreset = 1'b1;
                run_cnt_d  = run_inc;
                if (dct_finished) begin
                    state_d = ST_DONE;
                end else if (run_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                    err_d   = 1'b1;
                    in_pop  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                in_pop   = 1'b1;
                out_push = 1'b1;
                state_d  = ST_IDLE;
                if (blk_q == BLK_W'(BLOCKS_PER_FRAME - 1)) begin
                    blk_d      = '0;
                    frame_done = 1'b1;
                end else begin
                    blk_d = blk_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q   <= ST_IDLE;
            run_cnt_q <= '0;
            blk_q     <= '0;
            rd_sel_q  <= 1'b0;
            wr_sel_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            blk_q     <= blk_d;
            rd_sel_q  <= rd_sel_d;
            wr_sel_q  <= wr_sel_d;
            err_q     <= err_d;
        end
    end

    assign in_wr_sel   = in_wr_ptr;
    assign out_rd_sel  = out_rd_ptr;
    assign dct_rd_sel  = rd_sel_q;
    assign dct_wr_sel  = wr_sel_q;
    assign err_timeout = err_q;

endmodule
